instr_fetch_unit: RTL and testbench

Consumes the 8-bit byte-address stream produced by the program counter and turns each address into an instruction-memory read. It returns the fetched word, tagged with its address, to the decode stage through a valid/ready handshake. It sits between the PC register, instruction memory and decode. It also handles branch-redirect flushes, including discarding a read that is already in flight.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, default widths and the
// buffered fetch-entry layout.
package instr_fetch_pkg;

  localparam int unsigned IF_ADDR_W = 8;
  localparam int unsigned IF_DATA_W = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_WAIT_MEM = 2'd1,
    FETCH_DRAIN    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_DATA_W-1:0] instr;
    logic [IF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched entries; clear empties it and wins over push/pop.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  input  logic             clear,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Turns accepted PC addresses into single-outstanding instruction-memory reads and queues
// the tagged results for decode; FLUSH drops queued entries and any in-flight read.
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = IF_ADDR_W,
  parameter int unsigned DATA_W    = IF_DATA_W,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] PC_IN,
  input  logic              PC_VALID,
  output logic              PC_READY,
  input  logic              FLUSH,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] pend_pc_q;

  logic              accept;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Accepting only in IDLE with a free slot reserves room for the returning word.
  assign PC_READY = RST_N && (state_q == FETCH_IDLE) && (fifo_count < CNT_W'(BUF_DEPTH))
                    && !FLUSH;
  assign accept     = PC_VALID && PC_READY;
  assign push       = (state_q == FETCH_WAIT_MEM) && MEM_RVALID && !FLUSH;
  assign pop        = INSTR_VALID && INSTR_READY;
  assign push_entry = {MEM_RDATA, pend_pc_q};

  assign MEM_REQ     = mem_req_q;
  assign MEM_ADDR    = pend_pc_q;
  assign INSTR_VALID = !fifo_empty;
  assign INSTR       = head.instr;
  assign INSTR_PC    = head.pc;

  // pend_pc_q is both the request address and the tag of the outstanding read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= FETCH_IDLE;
      mem_req_q <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      mem_req_q <= accept;
      if (accept) begin
        pend_pc_q <= PC_IN;
      end
      unique case (state_q)
        FETCH_IDLE: begin
          if (accept) state_q <= FETCH_WAIT_MEM;
        end
        FETCH_WAIT_MEM: begin
          if (MEM_RVALID)  state_q <= FETCH_IDLE;
          else if (FLUSH)  state_q <= FETCH_DRAIN;
        end
        FETCH_DRAIN: begin
          if (MEM_RVALID) state_q <= FETCH_IDLE;
        end
        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .clear (FLUSH),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && fifo_full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] d;
    logic [7:0]  pc;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  PC_IN = '0;
  logic        PC_VALID = 1'b0;
  logic        PC_READY;
  logic        FLUSH = 1'b0;
  logic        MEM_REQ;
  logic [7:0]  MEM_ADDR;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTR;
  logic [7:0]  INSTR_PC;

  instr_fetch_unit #(
    .ADDR_W    (8),
    .DATA_W    (32),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .PC_IN       (PC_IN),
    .PC_VALID    (PC_VALID),
    .PC_READY    (PC_READY),
    .FLUSH       (FLUSH),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RDATA   (MEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // stimulus controls
  bit   rst_n_v = 1'b0;
  bit   src_en = 1'b1;
  bit   flush_v = 1'b0;
  bit   rdy_v = 1'b1;
  bit   spur_v = 1'b0;
  int   mem_lat = 1;
  bq_t  src_q;

  // memory responder
  int         mem_cnt = 0;
  logic [7:0] mem_a = '0;
  bit         seen_req;
  logic [7:0] seen_addr;

  // reference model
  int   m_out = 0;          // 0 none, 1 result wanted, 2 result to discard
  bit   m_req = 1'b0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_tag = '0;
  ent_t m_q[$];

  // observation
  bq_t  got_q;
  bq_t  req_q;
  bit   pop_ok;
  logic [7:0] pop_pc;
  int   cyc = 0;
  bit   lat_arm = 1'b0;
  int   acc_cyc = -1;
  int   val_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_list(input string tag, input bq_t got, input bq_t exp);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check_eq(tag, 32'(got[i]), 32'(exp[i]));
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hA5, ~a, a ^ 8'h3C, a};
  endfunction

  function automatic bit exp_ready();
    return rst_n_v && (m_out == 0) && (m_q.size() < DEPTH) && !flush_v;
  endfunction

  task automatic model_reset();
    m_out  = 0;
    m_req  = 1'b0;
    m_addr = '0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit   acc;
    ent_t e;
    if (!rst_n_v) begin
      model_reset();
      return;
    end
    acc = PC_VALID && exp_ready();
    if (flush_v) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && rdy_v) void'(m_q.pop_front());
      if (m_out == 1 && MEM_RVALID) begin
        e.d  = MEM_RDATA;
        e.pc = m_tag;
        m_q.push_back(e);
      end
    end
    if (m_out == 1) begin
      if (MEM_RVALID) m_out = 0;
      else if (flush_v) m_out = 2;
    end else if (m_out == 2) begin
      if (MEM_RVALID) m_out = 0;
    end else if (acc) begin
      m_out = 1;
      m_tag = PC_IN;
    end
    m_req = acc;
    if (acc) m_addr = PC_IN;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    if (lat_arm && acc && acc_cyc < 0) acc_cyc = cyc;
  endtask

  task automatic check_outputs();
    check_eq("pc_ready", 32'(PC_READY), 32'(exp_ready()));
    check_eq("mem_req", 32'(MEM_REQ), 32'(m_req));
    if (m_req || !rst_n_v) check_eq("mem_addr", 32'(MEM_ADDR), 32'(m_addr));
    check_eq("instr_valid", 32'(INSTR_VALID), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("instr", INSTR, m_q[0].d);
      check_eq("instr_pc", 32'(INSTR_PC), 32'(m_q[0].pc));
    end else if (!rst_n_v) begin
      check_eq("instr_rst", INSTR, 32'h0);
      check_eq("instr_pc_rst", 32'(INSTR_PC), 32'h0);
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic cycle();
    bit resp;
    RST_N = rst_n_v;
    if (!rst_n_v) model_reset();
    resp = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) resp = 1'b1;
    end
    MEM_RVALID  = resp || spur_v;
    MEM_RDATA   = resp ? mem_word(mem_a) : $urandom();
    PC_VALID    = src_en && (src_q.size() > 0);
    PC_IN       = PC_VALID ? src_q[0] : 8'($urandom());
    FLUSH       = flush_v;
    INSTR_READY = rdy_v;
    @(negedge CLK);
    check_outputs();
    seen_req  = MEM_REQ;
    seen_addr = MEM_ADDR;
    pop_ok    = INSTR_VALID && rdy_v && !flush_v;
    pop_pc    = INSTR_PC;
    if (MEM_REQ) req_q.push_back(MEM_ADDR);
    if (lat_arm && INSTR_VALID && acc_cyc >= 0 && val_cyc < 0) val_cyc = cyc;
    @(posedge CLK);
    model_update();
    if (pop_ok) got_q.push_back(pop_pc);
    if (seen_req) begin
      mem_cnt = mem_lat;
      mem_a   = seen_addr;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_obs();
    got_q.delete();
    req_q.delete();
  endtask

  initial begin
    bq_t exp;
    #1;
    // Reset with a PC offered: nothing may be accepted.
    rst_n_v = 1'b0;
    src_q = '{8'h70};
    run(3);
    src_q.delete();
    rst_n_v = 1'b1;
    run(2);

    // Stream 00,04,08 with decode always ready.
    clear_obs();
    lat_arm = 1'b1;
    mem_lat = 1;
    rdy_v   = 1'b1;
    src_q   = '{8'h00, 8'h04, 8'h08};
    run(14);
    lat_arm = 1'b0;
    check_eq("first_valid_latency", 32'(val_cyc - acc_cyc), 32'd3);
    exp = '{8'h00, 8'h04, 8'h08};
    check_list("t1_mem_addr", req_q, exp);
    check_list("t1_instr_pc", got_q, exp);

    // Back-pressure: two buffered, third waits until a pop.
    clear_obs();
    rdy_v = 1'b0;
    src_q = '{8'h00, 8'h04, 8'h08};
    run(10);
    check_eq("t2_pc_ready_full", 32'(PC_READY), 32'd0);
    check_eq("t2_src_left", 32'(src_q.size()), 32'd1);
    rdy_v = 1'b1;
    run(1);
    rdy_v = 1'b0;
    run(6);
    check_eq("t2_src_drained", 32'(src_q.size()), 32'd0);
    rdy_v = 1'b1;
    run(4);
    exp = '{8'h00, 8'h04, 8'h08};
    check_list("t2_instr_pc", got_q, exp);

    // Flush while waiting on memory; late response must be dropped.
    clear_obs();
    mem_lat = 2;
    src_q = '{8'h10};
    run(1);
    flush_v = 1'b1;
    run(1);
    flush_v = 1'b0;
    run(6);
    mem_lat = 1;
    src_q = '{8'h40};
    run(6);
    exp = '{8'h40};
    check_list("t3_instr_pc", got_q, exp);

    // Flush coinciding with the response, then flush with PC_VALID high.
    clear_obs();
    src_q = '{8'h20};
    run(2);
    flush_v = 1'b1;
    run(1);
    flush_v = 1'b0;
    run(3);
    src_q = '{8'h30};
    flush_v = 1'b1;
    run(1);
    check_eq("t4_not_accepted", 32'(src_q.size()), 32'd1);
    flush_v = 1'b0;
    run(5);
    exp = '{8'h30};
    check_list("t4_instr_pc", got_q, exp);

    // Address wrap FC -> 00.
    clear_obs();
    src_q = '{8'hFC, 8'h00};
    run(10);
    exp = '{8'hFC, 8'h00};
    check_list("t5_mem_addr", req_q, exp);
    check_list("t5_instr_pc", got_q, exp);

    // Reset mid-fetch, response arrives after release.
    clear_obs();
    mem_lat = 3;
    src_q = '{8'h50};
    run(2);
    src_q = '{8'h60};
    rst_n_v = 1'b0;
    run(1);
    src_en  = 1'b0;
    rst_n_v = 1'b1;
    run(6);
    check_eq("t6_no_instr", 32'(got_q.size()), 32'd0);
    check_eq("t6_valid_low", 32'(INSTR_VALID), 32'd0);
    src_q.delete();
    src_en = 1'b1;
    run(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && src_q.size() < 4) src_q.push_back(8'($urandom()));
      src_en  = ($urandom_range(0, 3) != 0);
      flush_v = ($urandom_range(0, 15) == 0);
      rdy_v   = $urandom_range(0, 1) != 0;
      mem_lat = $urandom_range(1, 3);
      spur_v  = (mem_cnt == 0) && (m_out == 0) && ($urandom_range(0, 7) == 0);
      cycle();
    end
    spur_v  = 1'b0;
    flush_v = 1'b0;
    rdy_v   = 1'b1;
    src_q.delete();
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
